// File: rtl/ovl_win_sched_if.sv
// Bundle of requester-side and checker-side signals for ovl_win_sched.
// The slave modport is the scheduler's view; master is the requester/bench side.
interface ovl_win_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ*WIDTH-1:0] test_expr;
  logic [NUM_REQ-1:0]       gnt;
  logic [ID_W-1:0]          gnt_id;
  logic                     start_event;
  logic                     end_event;
  logic                     window;
  logic [WIDTH-1:0]         sel_expr;
  logic                     fire;
  logic [ID_W-1:0]          fire_id;
  logic                     timeout;

  modport master (
    output req, done, test_expr,
    input  gnt, gnt_id, start_event, end_event, window, sel_expr, fire, fire_id, timeout
  );

  modport slave (
    input  req, done, test_expr,
    output gnt, gnt_id, start_event, end_event, window, sel_expr, fire, fire_id, timeout
  );
endinterface

// File: rtl/ovl_win_sched.sv
// Round-robin scheduler sharing one window-unchange checker among NUM_REQ requesters.
// Define OVL_WIN_SCHED_TIMEOUT_EN to enable the MAX_WIN forced close and timeout pulse.
module ovl_win_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2,
  parameter int MAX_WIN = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  ovl_win_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, OPEN, CLOSE} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 16 || (1 << ID_W) < NUM_REQ ||
      MAX_WIN < 1 || MAX_WIN > 65535) begin : g_bad_cfg
    $error("ovl_win_sched: invalid parameter combination");
  end

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic [ID_W-1:0]      gnt_id_reg, gnt_id_next;
  logic [ID_W-1:0]      ptr_reg, ptr_next;
  logic [WIDTH-1:0]     snap_reg, snap_next;
  logic                 fired_reg, fired_next;
  logic                 start_reg, start_next;
  logic                 end_reg, end_next;
  logic                 window_reg, window_next;
  logic                 fire_reg, fire_next;
  logic [ID_W-1:0]      fire_id_reg, fire_id_next;
`ifdef OVL_WIN_SCHED_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(MAX_WIN - 1);
  logic [15:0]          cnt_reg, cnt_next;
  logic                 timeout_reg, timeout_next;
`endif

  logic [WIDTH-1:0]     expr_arr [NUM_REQ];
  logic [WIDTH-1:0]     sel_expr;
  logic [ID_W-1:0]      win_id, hi_id, lo_id;
  logic                 hi_found;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign expr_arr[gi] = bus.test_expr[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign sel_expr = expr_arr[gnt_id_reg];

  // Round-robin: lowest set bit above ptr wins, otherwise wrap to lowest set bit.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        lo_id = ID_W'(i);
        if (i > int'(ptr_reg)) begin
          hi_id    = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    win_id = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    ptr_next     = ptr_reg;
    snap_next    = snap_reg;
    fired_next   = fired_reg;
    fire_next    = 1'b0;
    fire_id_next = fire_id_reg;
`ifdef OVL_WIN_SCHED_TIMEOUT_EN
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          state_next  = START;
          gnt_next    = NUM_REQ'(1) << win_id;
          gnt_id_next = win_id;
          ptr_next    = win_id;
        end
      end
      START: begin
        snap_next  = sel_expr;
        fired_next = 1'b0;
`ifdef OVL_WIN_SCHED_TIMEOUT_EN
        cnt_next   = '0;
`endif
        state_next = OPEN;
      end
      OPEN: begin
        // Compare runs on every OPEN edge, including the one that closes the window.
        if (sel_expr != snap_reg && !fired_reg) begin
          fire_next    = 1'b1;
          fire_id_next = gnt_id_reg;
          fired_next   = 1'b1;
        end
`ifdef OVL_WIN_SCHED_TIMEOUT_EN
        cnt_next = (cnt_reg == CNT_LAST) ? cnt_reg : cnt_reg + 16'd1;
`endif
        if (bus.done[gnt_id_reg]) begin
          state_next = CLOSE;
        end else if (!bus.req[gnt_id_reg]) begin
          state_next = CLOSE;
        end
`ifdef OVL_WIN_SCHED_TIMEOUT_EN
        else if (cnt_reg == CNT_LAST) begin
          state_next   = CLOSE;
          timeout_next = 1'b1;
        end
`endif
      end
      CLOSE: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    start_next  = (state_next == START);
    end_next    = (state_next == CLOSE);
    window_next = (state_next == OPEN) || (state_next == CLOSE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      ptr_reg     <= ID_W'(NUM_REQ - 1);
      snap_reg    <= '0;
      fired_reg   <= 1'b0;
      start_reg   <= 1'b0;
      end_reg     <= 1'b0;
      window_reg  <= 1'b0;
      fire_reg    <= 1'b0;
      fire_id_reg <= '0;
`ifdef OVL_WIN_SCHED_TIMEOUT_EN
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      ptr_reg     <= ptr_next;
      snap_reg    <= snap_next;
      fired_reg   <= fired_next;
      start_reg   <= start_next;
      end_reg     <= end_next;
      window_reg  <= window_next;
      fire_reg    <= fire_next;
      fire_id_reg <= fire_id_next;
`ifdef OVL_WIN_SCHED_TIMEOUT_EN
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
`endif
    end
  end

  assign bus.gnt         = gnt_reg;
  assign bus.gnt_id      = gnt_id_reg;
  assign bus.start_event = start_reg;
  assign bus.end_event   = end_reg;
  assign bus.window      = window_reg;
  assign bus.sel_expr    = sel_expr;
  assign bus.fire        = fire_reg;
  assign bus.fire_id     = fire_id_reg;
`ifdef OVL_WIN_SCHED_TIMEOUT_EN
  assign bus.timeout     = timeout_reg;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_ovl_win_sched.sv
// Directed bench for ovl_win_sched: grant timing, change detection, round-robin,
// timeout/no-timeout, abandon and asynchronous reset.
module tb_ovl_win_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;
  localparam int MAX_WIN = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   fire_cnt = 0;
  int   end_cnt = 0;
  int   to_cnt = 0;
  int   base;

  ovl_win_sched_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  ovl_win_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W), .MAX_WIN(MAX_WIN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Single-cycle pulses are counted once each on the falling edge.
  always @(negedge clk) begin
    if (bus.fire === 1'b1)      fire_cnt++;
    if (bus.end_event === 1'b1) end_cnt++;
    if (bus.timeout === 1'b1)   to_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    bus.req       = '0;
    bus.done      = '0;
    bus.test_expr = '0;

    // Reset state
    tick(); tick();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 0);
    chk("rst_start", 32'(bus.start_event), 0);
    chk("rst_end", 32'(bus.end_event), 0);
    chk("rst_window", 32'(bus.window), 0);
    chk("rst_fire", 32'(bus.fire), 0);
    chk("rst_fire_id", 32'(bus.fire_id), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    reset_n = 1'b1;

    // Single requester, constant expression
    base = fire_cnt;
    bus.req = 4'b0001;
    bus.test_expr[7:0] = 8'h5A;
    tick();
    chk("t1_start", 32'(bus.start_event), 1);
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    chk("t1_window_start", 32'(bus.window), 0);
    chk("t1_sel", 32'(bus.sel_expr), 32'h5A);
    tick();
    chk("t1_window_open", 32'(bus.window), 1);
    chk("t1_start_low", 32'(bus.start_event), 0);
    tick(); tick();
    bus.done = 4'b0001;
    tick();
    bus.done = '0;
    chk("t1_end", 32'(bus.end_event), 1);
    chk("t1_window_close", 32'(bus.window), 1);
    chk("t1_gnt_close", 32'(bus.gnt), 32'h1);
    tick();
    chk("t1_window_idle", 32'(bus.window), 0);
    chk("t1_gnt_idle", 32'(bus.gnt), 0);
    chk("t1_end_low", 32'(bus.end_event), 0);
    chk("t1_gnt_id_kept", 32'(bus.gnt_id), 0);
    chk("t1_no_fire", 32'(fire_cnt - base), 0);
    bus.req = '0;
    $display("txn single req0 window done");

    // Change inside window on requester 2
    base = fire_cnt;
    bus.req = 4'b0100;
    bus.test_expr[23:16] = 8'h11;
    tick();
    chk("t2_gnt_id", 32'(bus.gnt_id), 2);
    chk("t2_gnt", 32'(bus.gnt), 32'h4);
    tick();
    bus.test_expr[23:16] = 8'h12;
    tick();
    chk("t2_fire", 32'(bus.fire), 1);
    chk("t2_fire_id", 32'(bus.fire_id), 2);
    bus.test_expr[23:16] = 8'h13;
    #1;
    chk("t2_sel", 32'(bus.sel_expr), 32'h13);
    tick();
    chk("t2_fire_once", 32'(bus.fire), 0);
    bus.done = 4'b0100;
    tick();
    bus.done = '0;
    chk("t2_end", 32'(bus.end_event), 1);
    tick();
    chk("t2_fire_count", 32'(fire_cnt - base), 1);
    bus.req = '0;
    $display("txn change req2 fire_id=%0d", bus.fire_id);

    // Round-robin from reset with all requesters and immediate done
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.req  = 4'b1111;
    bus.done = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("t3_start", 32'(bus.start_event), 1);
      chk("t3_gnt_id", 32'(bus.gnt_id), 32'(g % 4));
      tick(); tick();
      chk("t3_end", 32'(bus.end_event), 1);
      tick();
      chk("t3_gap", 32'(bus.start_event), 0);
      $display("txn rr grant %0d", g % 4);
    end
    bus.req  = '0;
    bus.done = '0;

    // Long window on requester 3: times out only with the feature enabled
    base = to_cnt;
    bus.req = 4'b1000;
    tick();
    chk("t4_gnt_id", 32'(bus.gnt_id), 3);
    tick();
    for (int i = 0; i < MAX_WIN - 1; i++) tick();
    chk("t4_not_yet", 32'(bus.end_event), 0);
    tick();
`ifdef OVL_WIN_SCHED_TIMEOUT_EN
    chk("t4_timeout", 32'(bus.timeout), 1);
    chk("t4_end", 32'(bus.end_event), 1);
    tick();
    chk("t4_window_off", 32'(bus.window), 0);
    chk("t4_timeout_once", 32'(to_cnt - base), 1);
`else
    chk("t4_no_timeout", 32'(bus.timeout), 0);
    chk("t4_still_open", 32'(bus.window), 1);
    bus.done = 4'b1000;
    tick();
    bus.done = '0;
    chk("t4_end_done", 32'(bus.end_event), 1);
    tick();
    chk("t4_timeout_cnt", 32'(to_cnt - base), 0);
`endif
    bus.req = '0;
    $display("txn long window req3");

    // Abandon: requester 1 drops req in OPEN
    base = fire_cnt;
    bus.req = 4'b0010;
    tick();
    chk("t5_gnt_id", 32'(bus.gnt_id), 1);
    tick(); tick();
    bus.req = '0;
    tick();
    chk("t5_end", 32'(bus.end_event), 1);
    tick();
    chk("t5_window_off", 32'(bus.window), 0);
    chk("t5_no_fire", 32'(fire_cnt - base), 0);
    $display("txn abandon req1");

    // Asynchronous reset mid-OPEN
    bus.req = 4'b0100;
    tick();
    chk("t6_gnt_id", 32'(bus.gnt_id), 2);
    tick(); tick();
    base = end_cnt;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(bus.gnt), 0);
    chk("t6_rst_window", 32'(bus.window), 0);
    chk("t6_rst_gnt_id", 32'(bus.gnt_id), 0);
    tick();
    reset_n = 1'b1;
    bus.req = 4'b0101;
    tick();
    chk("t6_regrant_id", 32'(bus.gnt_id), 0);
    chk("t6_regrant_gnt", 32'(bus.gnt), 32'h1);
    chk("t6_no_end", 32'(end_cnt - base), 0);
    bus.req = '0;
    $display("txn reset mid-window then regrant 0");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
